multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle MIPS32 main control FSM; successor to the single-cycle opcode decoder.
//  Sequences FETCH/DECODE/EXECUTE/MEM/WB per instruction and stalls on a memory ready handshake.
//  Drives datapath muxes, register-file and PC enables. Detects bus timeouts and illegal opcodes.
//  Sits between the shared instruction/data memory port and the multi-cycle datapath.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max consecutive mem_ready=0 cycles in a memory state before bus error (>=1)
//  TIMEOUT_W       5   wait-counter width; must satisfy 2**TIMEOUT_W > TIMEOUT_CYCLES
//  EN_BNE          1   1: decode bne (000101); 0: bne is illegal
// PORTS
//  clk          in   1  rising-edge clock
//  reset        in   1  asynchronous, active-high reset
//  opcode       in   6  IR[31:26]; sampled in DECODE
//  zero         in   1  ALU zero flag; used in BRANCH
//  mem_ready    in   1  memory completes the current access this cycle
//  mem_read     out  1  read request; held until mem_ready
//  mem_write    out  1  write request; held until mem_ready
//  i_or_d       out  1  0: address=PC, 1: address=ALUOut
//  ir_write     out  1  load IR
//  pc_write     out  1  PC load enable, unconditional or branch-qualified
//  reg_dst      out  1  1: rd, 0: rt
//  reg_write    out  1  register-file write enable
//  mem_to_reg   out  1  1: MDR, 0: ALUOut
//  ext_op       out  1  1: sign-extend immediate, 0: zero-extend immediate
//  alu_src_a    out  1  0: PC, 1: reg A
//  alu_src_b    out  2  00: B, 01: const 4, 10: ext imm, 11: ext imm<<2
//  alu_op       out  2  00: add, 01: sub, 10: use funct, 11: use opcode (immediate ops)
//  pc_src       out  2  00: ALU result, 01: ALUOut, 10: jump target
//  bus_err      out  1  sticky: memory timeout
//  illegal_op   out  1  sticky: undecodable opcode
// BEHAVIOUR
//  - Registered state; outputs are a Moore decode of state. Exception: pc_write in BRANCH.
//  - Reset (async): state=IDLE, wait counter=0, bus_err=0, illegal_op=0.
//    All outputs 0, except ext_op=1 (never X).
//  - IDLE: all outputs 0; advances to FETCH on the next clk.
//  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
//    While mem_ready=0: stay, with ir_write=pc_write=0.
//    On mem_ready=1: ir_write=pc_write=1 in the same cycle, then DECODE.
//  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target to ALUOut). Opcode dispatch:
//      000000 -> RTYPE; 100011/101011 -> MEMADR; 000100/000101 -> BRANCH; 000010 -> JUMP;
//      001000/001010/001100/001101/001110 -> IMM; any other -> TRAP with illegal_op=1.
//  - ext_op=0 only for andi/ori/xori; 1 for all other opcodes and states.
//  - RTYPE: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALUWB_R.
//  - ALUWB_R: reg_dst=1, reg_write=1, mem_to_reg=0 -> FETCH.
//  - IMM: alu_src_a=1, alu_src_b=10, alu_op=11 -> ALUWB_I.
//  - ALUWB_I: reg_dst=0, reg_write=1, mem_to_reg=0 -> FETCH.
//  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00 -> MEMRD (lw) or MEMWR (sw).
//  - MEMRD / MEMWR: i_or_d=1, with mem_read=1 or mem_write=1. Hold until mem_ready.
//    MEMRD -> MEMWB; MEMWR -> FETCH.
//  - MEMWB: reg_dst=0, reg_write=1, mem_to_reg=1 -> FETCH.
//  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01 -> FETCH.
//    pc_write = beq ? zero : ~zero (Mealy on zero).
//  - JUMP: pc_src=10, pc_write=1 -> FETCH.
//  - Wait counter: increments each cycle in FETCH/MEMRD/MEMWR with mem_ready=0.
//    Clears on mem_ready=1 and on leaving the state.
//    On the cycle it equals TIMEOUT_CYCLES-1 with mem_ready=0: -> TRAP, bus_err=1.
//    mem_ready=1 in that same cycle wins: no error.
//  - TRAP: all enables/requests 0. Absorbing; exits only via reset. Sticky flags hold.
//  - Reset mid-access: drops mem_read/mem_write immediately, no stray writes.
// STRUCTURE
//  - Shared package mips_ctrl_pkg: opcode localparams, state encoding (4-bit),
//    alu_op/alu_src_b/pc_src encodings.
//  - One sub-module: mem_wait_timer (counter + timeout compare, parametrised by TIMEOUT_*).
// TESTING
//  - Reset held 3 clk then released: IDLE 1 cycle, then FETCH with mem_read=1, i_or_d=0.
//  - lw (100011), mem_ready low 3 cycles in MEMRD: mem_read held 4 cycles.
//    reg_write=1, mem_to_reg=1 exactly once. Total 5 states + 3 waits.
//  - beq, zero=1 -> pc_write=1, pc_src=01 in BRANCH.
//    bne, zero=1 -> pc_write=0. EN_BNE=0 + bne -> TRAP, illegal_op=1.
//  - andi (001100) -> ext_op=0 in IMM.
//    addi (001000) -> ext_op=1, alu_op=11, reg_dst=0 at writeback.
//  - TIMEOUT_CYCLES=4, mem_ready=0 in FETCH -> TRAP after 4 cycles, bus_err=1.
//    mem_ready=1 on 4th cycle -> no error.
//  - Assert reset during MEMWR wait -> mem_write=0 same cycle, flags cleared, IDLE.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multi-cycle MIPS32 main control FSM:
//   - opcode constants (IR[31:26])
//   - 4-bit FSM state encoding
//   - datapath mux select encodings (alu_op, alu_src_b, pc_src)
//   - helper to classify zero-extended (logical) immediate opcodes
// ---------------------------------------------------------------------------
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWR   = 4'd5,
        S_MEMWB   = 4'd6,
        S_RTYPE   = 4'd7,
        S_ALUWB_R = 4'd8,
        S_IMM     = 4'd9,
        S_ALUWB_I = 4'd10,
        S_BRANCH  = 4'd11,
        S_JUMP    = 4'd12,
        S_TRAP    = 4'd13
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_IMM   = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alu_src_b_e;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10
    } pc_src_e;

    // Logical immediates take a zero-extended operand; everything else sign-extends.
    function automatic logic is_logical_imm(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// ---------------------------------------------------------------------------
// mem_wait_timer
// Counts consecutive cycles a memory access is stalled (active && !mem_ready)
// and flags a bus timeout on the TIMEOUT_CYCLES-th stalled cycle.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   active     in   FSM is in a memory-access state this cycle
//   mem_ready  in   memory completes the access this cycle
//   timeout    out  this is the last tolerated stall cycle (combinational)
// ---------------------------------------------------------------------------
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TIMEOUT_W      = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic mem_ready,
    output logic timeout
);

    localparam logic [TIMEOUT_W-1:0] LAST_WAIT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] cnt_q;
    logic [TIMEOUT_W-1:0] cnt_d;

    always_comb begin
        // mem_ready in the final cycle suppresses the timeout.
        timeout = active && !mem_ready && (cnt_q == LAST_WAIT);
        // Any cycle that is not a continuing stall (ready, idle, or leaving
        // the state through a timeout) restarts the count from zero.
        cnt_d = '0;
        if (active && !mem_ready && !timeout) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Main control FSM for a multi-cycle MIPS32 datapath. Sequences
// FETCH/DECODE/EXECUTE/MEM/WB, stalls on the memory ready handshake, and
// traps (absorbing until reset) on bus timeouts and illegal opcodes.
// Ports:
//   clk, reset                       clock, async active-high reset
//   opcode[5:0]                      IR[31:26], sampled in DECODE
//   zero                             ALU zero flag (branch qualification)
//   mem_ready                        memory completes current access
//   mem_read, mem_write, i_or_d      memory request / address select
//   ir_write, pc_write               IR and PC load enables
//   reg_dst, reg_write, mem_to_reg   register-file write controls
//   ext_op                           1: sign-extend imm, 0: zero-extend
//   alu_src_a, alu_src_b[1:0]        ALU operand selects
//   alu_op[1:0], pc_src[1:0]         ALU function class, PC source select
//   bus_err, illegal_op              sticky error flags
// ---------------------------------------------------------------------------
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TIMEOUT_W      = 5,
    parameter bit EN_BNE         = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       ext_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       bus_err,
    output logic       illegal_op
);

    state_e     state_q, state_d;
    logic [5:0] op_q, op_d;          // opcode captured in DECODE for later states
    logic       bus_err_q, bus_err_d;
    logic       illegal_op_q, illegal_op_d;
    logic       mem_active;
    logic       timeout;

    assign mem_active = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

    mem_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_W      (TIMEOUT_W)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .active    (mem_active),
        .mem_ready (mem_ready),
        .timeout   (timeout)
    );

    // Next-state logic
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d      = state_q;
        op_d         = op_q;
        bus_err_d    = bus_err_q;
        illegal_op_d = illegal_op_q;

        case (state_q)
            S_IDLE:    state_d = S_FETCH;
            S_FETCH:   if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                op_d = opcode;
                case (opcode)
                    OP_RTYPE:                               state_d = S_RTYPE;
                    OP_LW, OP_SW:                           state_d = S_MEMADR;
                    OP_BEQ:                                 state_d = S_BRANCH;
                    OP_J:                                   state_d = S_JUMP;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: state_d = S_IMM;
                    OP_BNE: begin
                        if (EN_BNE) begin
                            state_d = S_BRANCH;
                        end else begin
                            state_d      = S_TRAP;
                            illegal_op_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d      = S_TRAP;
                        illegal_op_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:   if (mem_ready) state_d = S_FETCH;
            S_MEMWB,
            S_ALUWB_R,
            S_ALUWB_I,
            S_BRANCH,
            S_JUMP:    state_d = S_FETCH;
            S_RTYPE:   state_d = S_ALUWB_R;
            S_IMM:     state_d = S_ALUWB_I;
            S_TRAP:    state_d = S_TRAP;
            default:   state_d = S_TRAP;
        endcase

        // The timer only fires in a stalled memory state, so it overrides the
        // "stay" decision made above.
        if (timeout) begin
            state_d   = S_TRAP;
            bus_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            bus_err_q    <= 1'b0;
            illegal_op_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            bus_err_q    <= bus_err_d;
            illegal_op_q <= illegal_op_d;
        end
    end

    // Output decode: Moore on state, except the handshake-qualified IR/PC
    // writes in FETCH and the zero-qualified PC write in BRANCH.
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        ext_op     = 1'b1;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_op     = ALU_ADD;
        pc_src     = PC_ALU;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE:  alu_src_b = SRCB_IMM_SH2;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_RTYPE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_ALUWB_R: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_IMM: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_IMM;
                ext_op    = ~is_logical_imm(op_q);
            end
            S_ALUWB_I: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PC_ALUOUT;
                pc_write  = (op_q == OP_BEQ) ? zero : ~zero;
            end
            S_JUMP: begin
                pc_src   = PC_JUMP;
                pc_write = 1'b1;
            end
            default: ;  // IDLE, TRAP: all enables and requests stay low
        endcase
    end

    assign bus_err    = bus_err_q;
    assign illegal_op = illegal_op_q;

endmodule
